// File: rtl/rca_repair_ctrl_if.sv
// Signal bundle between the repair controller and the reconfigurable adder array.
// The master side (the controller) drives test stimulus, steering selects and status.
interface rca_repair_ctrl_if;
    logic       start;
    logic [3:0] adder_sums;
    logic [3:0] adder_carrys;
    logic       test;
    logic [3:0] at;
    logic [3:0] bt;
    logic       cint;
    logic [2:0] is0;
    logic [2:0] is1;
    logic [4:0] cs;
    logic [3:0] ss0;
    logic [3:0] ss1;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fault_map;

    modport master (
        input  start, adder_sums, adder_carrys,
        output test, at, bt, cint, is0, is1, cs, ss0, ss1, busy, done, pass, fault_map
    );

    modport slave (
        output start, adder_sums, adder_carrys,
        input  test, at, bt, cint, is0, is1, cs, ss0, ss1, busy, done, pass, fault_map
    );
endinterface

// File: rtl/rca_repair_ctrl.sv
// BIST and self-repair controller for the 6-adder double-fault ripple-carry adder:
// sweeps all 512 test vectors, isolates faulty fa0-fa3, then steers onto a clean chain.
module rca_repair_ctrl #(
    parameter int SETTLE     = 0,
    parameter bit AUTO_START = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    rca_repair_ctrl_if.master     bus
);

    typedef enum logic [1:0] {IDLE, SWEEP, EVAL, DONE} state_t;

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_V = SW'(SETTLE);

    // {is0, is1, cs, ss0, ss1}
    localparam logic [18:0] CFG_0123 = {3'b000, 3'b000, 5'b10000, 4'b0000, 4'b0000};
    localparam logic [18:0] CFG_0125 = {3'b000, 3'b000, 5'b01000, 4'b0000, 4'b1000};
    localparam logic [18:0] CFG_0145 = {3'b100, 3'b100, 5'b00100, 4'b1000, 4'b1100};
    localparam logic [18:0] CFG_0345 = {3'b110, 3'b110, 5'b00010, 4'b1100, 4'b1110};
    localparam logic [18:0] CFG_2345 = {3'b111, 3'b111, 5'b00001, 4'b1110, 4'b1111};
    localparam logic [18:0] CFG_TEST = {3'b000, 3'b000, 5'b00011, 4'b0000, 4'b0000};

    state_t        r_state;
    state_t        w_state_nx;
    logic          r_auto;
    logic [8:0]    r_p;
    logic [SW-1:0] r_settle;
    logic          r_swept;
    logic          r_test;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;
    logic [3:0]    r_fmap;
    logic [18:0]   r_cfg;

    logic [3:0]    w_at;
    logic [3:0]    w_bt;
    logic          w_hit;
    logic [1:0]    w_ref [4];
    logic [3:0]    w_err;
    logic          w_pass;
    logic [18:0]   w_cfg_eval;

    function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    assign w_at  = r_p[8:5];
    assign w_bt  = r_p[4:1];
    assign w_hit = (r_state == SWEEP) && !r_swept && (r_settle == SETTLE_V);

    // Each adder is judged against its own observed carry-in, so an upstream carry
    // fault in fa0 is not blamed on fa1 or fa3.
    always_comb begin
        w_ref[0] = fa_ref(w_at[0], w_bt[0], r_p[0]);
        w_ref[1] = fa_ref(w_at[1], w_bt[1], bus.adder_carrys[0]);
        w_ref[2] = fa_ref(w_at[2], w_bt[2], r_p[0]);
        w_ref[3] = fa_ref(w_at[3], w_bt[3], bus.adder_carrys[0]);
        for (int i = 0; i < 4; i++) begin
            w_err[i] = ({bus.adder_carrys[i], bus.adder_sums[i]} != w_ref[i]);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_pass     = 1'b1;
        w_cfg_eval = CFG_0123;
        if (r_fmap == 4'b0000) begin
            w_cfg_eval = CFG_0123;
        end else if (!r_fmap[0] && !r_fmap[1] && !r_fmap[2]) begin
            w_cfg_eval = CFG_0125;
        end else if (!r_fmap[0] && !r_fmap[1]) begin
            w_cfg_eval = CFG_0145;
        end else if (!r_fmap[0] && !r_fmap[3]) begin
            w_cfg_eval = CFG_0345;
        end else if (!r_fmap[2] && !r_fmap[3]) begin
            w_cfg_eval = CFG_2345;
        end else begin
            w_pass     = 1'b0;
            w_cfg_eval = CFG_0123;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (bus.start || r_auto) w_state_nx = SWEEP;
            SWEEP:   if (r_swept)             w_state_nx = EVAL;
            EVAL:                             w_state_nx = DONE;
            DONE:    if (bus.start)           w_state_nx = SWEEP;
            default:                          w_state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_auto   <= AUTO_START;
            r_p      <= '0;
            r_settle <= '0;
            r_swept  <= 1'b0;
            r_test   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fmap   <= '0;
            r_cfg    <= CFG_0123;
        end else begin
            r_auto <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_state_nx == SWEEP) begin
                        r_p      <= '0;
                        r_settle <= '0;
                        r_swept  <= 1'b0;
                        r_test   <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_pass   <= 1'b0;
                        r_fmap   <= '0;
                        r_cfg    <= CFG_TEST;
                    end
                end
                SWEEP: begin
                    if (w_hit) begin
                        // The counter wraps to 0 after vector 511, leaving at/bt/cint idle.
                        r_fmap   <= r_fmap | w_err;
                        r_p      <= r_p + 9'd1;
                        r_settle <= '0;
                        if (r_p == 9'd511) r_swept <= 1'b1;
                    end else if (!r_swept) begin
                        r_settle <= r_settle + 1'b1;
                    end
                end
                EVAL: begin
                    r_test <= 1'b0;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_pass <= w_pass;
                    r_cfg  <= w_cfg_eval;
                end
                default: ;
            endcase
        end
    end

    assign bus.test      = r_test;
    assign bus.at        = w_at;
    assign bus.bt        = w_bt;
    assign bus.cint      = r_p[0];
    assign bus.is0       = r_cfg[18:16];
    assign bus.is1       = r_cfg[15:13];
    assign bus.cs        = r_cfg[12:8];
    assign bus.ss0       = r_cfg[7:4];
    assign bus.ss1       = r_cfg[3:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fault_map = r_fmap;

endmodule

// File: tb/tb_rca_repair_ctrl.sv
// Directed bench for rca_repair_ctrl: a faultable behavioural adder array feeds one
// controller (AUTO_START=0); a second fault-free controller (AUTO_START=1) covers reset.
module tb_rca_repair_ctrl;

    typedef struct packed {
        logic [5:0] s0;
        logic [5:0] s1;
        logic [5:0] c0;
        logic [5:0] c1;
    } fault_t;

    localparam logic [18:0] CFG_0123 = {3'b000, 3'b000, 5'b10000, 4'b0000, 4'b0000};
    localparam logic [18:0] CFG_0125 = {3'b000, 3'b000, 5'b01000, 4'b0000, 4'b1000};
    localparam logic [18:0] CFG_0145 = {3'b100, 3'b100, 5'b00100, 4'b1000, 4'b1100};
    localparam logic [18:0] CFG_0345 = {3'b110, 3'b110, 5'b00010, 4'b1100, 4'b1110};
    localparam logic [18:0] CFG_2345 = {3'b111, 3'b111, 5'b00001, 4'b1110, 4'b1111};
    localparam logic [35:0] RST_OBS  = {1'b0, 4'h0, 4'h0, 1'b0, CFG_0123, 1'b0, 1'b0, 1'b0, 4'h0};

    logic   clk = 1'b0;
    logic   rst0;
    logic   rst1;
    fault_t flt0;
    int     n_checks = 0;
    int     n_err    = 0;

    rca_repair_ctrl_if bus0 ();
    rca_repair_ctrl_if bus1 ();

    rca_repair_ctrl #(.SETTLE(0), .AUTO_START(1'b0)) u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));
    rca_repair_ctrl #(.SETTLE(0), .AUTO_START(1'b1)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    always #5 clk = ~clk;

    function automatic logic [1:0] fa_cell(input int idx, input logic a, input logic b,
                                           input logic c, input fault_t f);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (a & c) | (b & c);
        if (f.s0[idx]) s  = 1'b0;
        if (f.s1[idx]) s  = 1'b1;
        if (f.c0[idx]) co = 1'b0;
        if (f.c1[idx]) co = 1'b1;
        return {co, s};
    endfunction

    // Test-mode wiring: fa0/fa2 take cint, fa1/fa3 take fa0's carry. Returns {carrys, sums}.
    function automatic logic [7:0] test_array(input logic [3:0] a, input logic [3:0] b,
                                              input logic ci, input fault_t f);
        logic [1:0] r0, r1, r2, r3;
        r0 = fa_cell(0, a[0], b[0], ci, f);
        r1 = fa_cell(1, a[1], b[1], r0[1], f);
        r2 = fa_cell(2, a[2], b[2], ci, f);
        r3 = fa_cell(3, a[3], b[3], r0[1], f);
        return {r3[1], r2[1], r1[1], r0[1], r3[0], r2[0], r1[0], r0[0]};
    endfunction

    // Mission-mode add along the chain selected by the steering configuration: {cout, sum}.
    function automatic logic [4:0] mission_add(input logic [18:0] cfg, input logic [3:0] a,
                                               input logic [3:0] b, input logic ci,
                                               input fault_t f);
        int         ch [4];
        logic       ok;
        logic       c;
        logic [3:0] s;
        logic [1:0] r;
        ok = 1'b1;
        ch = '{0, 1, 2, 3};
        case (cfg)
            CFG_0123: ch = '{0, 1, 2, 3};
            CFG_0125: ch = '{0, 1, 2, 5};
            CFG_0145: ch = '{0, 1, 4, 5};
            CFG_0345: ch = '{0, 3, 4, 5};
            CFG_2345: ch = '{2, 3, 4, 5};
            default:  ok = 1'b0;
        endcase
        c = ci;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            r    = fa_cell(ch[i], a[i], b[i], c, f);
            s[i] = r[0];
            c    = r[1];
        end
        return ok ? {c, s} : 5'bxxxxx;
    endfunction

    always_comb {bus0.adder_carrys, bus0.adder_sums} = test_array(bus0.at, bus0.bt, bus0.cint, flt0);
    always_comb {bus1.adder_carrys, bus1.adder_sums} = test_array(bus1.at, bus1.bt, bus1.cint, '0);

    logic [18:0] cfg0;
    logic [35:0] obs0;
    logic [35:0] obs1;
    assign cfg0 = {bus0.is0, bus0.is1, bus0.cs, bus0.ss0, bus0.ss1};
    assign obs0 = {bus0.test, bus0.at, bus0.bt, bus0.cint, cfg0,
                   bus0.busy, bus0.done, bus0.pass, bus0.fault_map};
    assign obs1 = {bus1.test, bus1.at, bus1.bt, bus1.cint,
                   bus1.is0, bus1.is1, bus1.cs, bus1.ss0, bus1.ss1,
                   bus1.busy, bus1.done, bus1.pass, bus1.fault_map};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start a sweep on dut0, check the first cycle and the latency, then the result.
    task automatic sweep0(input string tag, input logic [3:0] exp_map, input logic exp_pass,
                          input logic [18:0] exp_cfg);
        int n;
        @(negedge clk);
        bus0.start = 1'b1;
        @(posedge clk);
        #1 bus0.start = 1'b0;
        @(negedge clk);
        check({tag, "_first"}, {bus0.busy, bus0.test, bus0.done, bus0.at, bus0.bt, bus0.cint, bus0.cs},
              {3'b110, 9'd0, 5'b00011});
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (bus0.done) break;
        end
        check({tag, "_latency"}, n, 514);
        check({tag, "_map"}, bus0.fault_map, exp_map);
        check({tag, "_pass"}, {bus0.pass, bus0.done, bus0.busy, bus0.test}, {exp_pass, 3'b100});
        check({tag, "_cfg"}, cfg0, exp_cfg);
        check({tag, "_idle_ops"}, {bus0.at, bus0.bt, bus0.cint}, 9'd0);
    endtask

    initial begin
        int n;
        int bad;
        logic [4:0] exp_sum;
        rst0       = 1'b1;
        rst1       = 1'b1;
        flt0       = '0;
        bus0.start = 1'b0;
        bus1.start = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_dut0", obs0, RST_OBS);
        check("reset_dut1", obs1, RST_OBS);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("no_auto_dut0", {bus0.busy, bus0.test, bus0.done}, 3'b000);
        check("auto_dut1", {bus1.busy, bus1.test, bus1.done}, 3'b110);

        // Fault-free array.
        sweep0("t1", 4'b0000, 1'b1, CFG_0123);

        // fa2 sum stuck-at-0.
        flt0 = '0;
        flt0.s0 = 6'b000100;
        sweep0("t2", 4'b0100, 1'b1, CFG_0145);
        check("t2_f_plus_1", mission_add(cfg0, 4'hF, 4'h1, 1'b0, flt0), 5'h10);

        // fa1 carry stuck-at-1 plus fa2 sum stuck-at-1.
        flt0 = '0;
        flt0.c1 = 6'b000010;
        flt0.s1 = 6'b000100;
        sweep0("t3", 4'b0110, 1'b1, CFG_0345);
        bad = 0;
        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv      = 9'(v);
            exp_sum = 5'(vv[8:5]) + 5'(vv[4:1]) + 5'(vv[0]);
            if (mission_add(cfg0, vv[8:5], vv[4:1], vv[0], flt0) !== exp_sum) bad++;
        end
        check("t3_exhaustive_bad", bad, 0);

        // fa0 and fa2 faulty: no clean chain exists.
        flt0 = '0;
        flt0.s0 = 6'b000101;
        sweep0("t4", 4'b0101, 1'b0, CFG_0123);

        // Only fa0 faulty.
        flt0 = '0;
        flt0.s1 = 6'b000001;
        sweep0("t5", 4'b0001, 1'b1, CFG_2345);
        check("t5_7_9_1", mission_add(cfg0, 4'h7, 4'h9, 1'b1, flt0), 5'h11);

        // Reset dut1 mid-sweep at vector 200, then rely on auto-start.
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        n = 0;
        while (n < 1000 && {bus1.at, bus1.bt, bus1.cint} != 9'd200) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_v200", {bus1.at, bus1.bt, bus1.cint}, 9'd200);
        rst1 = 1'b1;
        #1;
        check("t6_async_reset", obs1, RST_OBS);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t6_reset_held", obs1, RST_OBS);
        rst1 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_restart", {bus1.busy, bus1.test, bus1.done, bus1.fault_map}, {3'b110, 4'h0});
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            bus1.start = (n == 10 || n == 300) ? 1'b1 : 1'b0;
            if (bus1.done) break;
        end
        bus1.start = 1'b0;
        check("t6_latency", n, 514);
        check("t6_result", {bus1.pass, bus1.fault_map, bus1.busy, bus1.test}, {1'b1, 4'h0, 2'b00});
        check("t6_cfg", {bus1.is0, bus1.is1, bus1.cs, bus1.ss0, bus1.ss1}, CFG_0123);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
